// File: rtl/wdma_pkg.sv
// Shared definitions for the gmem write DMA.
//   state_t   : state encoding used by the main FSM and the AW FSM
//   AXI_*     : AXI burst type, response code and 4 KB page size
//   burst_len : beats in the next burst. It is the smallest of the
//               remaining beats, the burst cap and the beats left in the page.
package wdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [12:0] AXI_4K         = 13'h1000;

  function automatic logic [8:0] burst_len(input logic [63:0] remaining,
                                           input logic [8:0]  cap,
                                           input logic [12:0] to_4k);
    logic [63:0] m;
    m = remaining;
    m = (m > 64'(cap))   ? 64'(cap)   : m;
    m = (m > 64'(to_4k)) ? 64'(to_4k) : m;
    return 9'(m);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO.
//   clk/rst_n  : clock and asynchronous active-low reset
//   push/din   : write port. A push while full is dropped.
//   pop/dout   : read port. dout shows the head entry whenever empty is low.
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW:0]   C_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   C_MAX = (PW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wp_r;
  logic [PW-1:0]    rp_r;
  logic [PW:0]      cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (cnt_r == C_MAX);
  assign empty     = (cnt_r == {(PW + 1){1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rp_r];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wp_r] <= din;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r  <= {PW{1'b0}};
      rp_r  <= {PW{1'b0}};
      cnt_r <= {(PW + 1){1'b0}};
    end else begin
      if (push_ok_s) wp_r <= wp_r + P_ONE;
      if (pop_ok_s)  rp_r <= rp_r + P_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + C_ONE;
        2'b01:   cnt_r <= cnt_r - C_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/wdma_mb.sv
// Write DMA: turns the accelerator output stream (wr_en/full_n/din) into
// AXI4 INCR write bursts to gmem.
//   ap_*              : start/idle/ready/done handshake and sticky BRESP error
//   transfer_byte/mem : byte count and base address, latched at launch
//   m_axi_gmem_*      : AXI4 write master (AW, W and B channels)
//   wr_en/full_n/din  : input stream. A beat is taken only while a burst
//                       address has already been issued.
module wdma_mb
  import wdma_pkg::*;
#(
  parameter int C_M_AXI_GMEM_ID_WIDTH     = 1,
  parameter int C_M_AXI_GMEM_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_GMEM_DATA_WIDTH   = 64,
  parameter int C_M_AXI_GMEM_AWUSER_WIDTH = 1,
  parameter int C_M_AXI_GMEM_WUSER_WIDTH  = 1,
  parameter int C_M_AXI_GMEM_BUSER_WIDTH  = 1,
  parameter int MAX_BURST_LEN             = 16,
  parameter int MAX_OUTSTANDING           = 4
) (
  input  logic                                    ap_clk,
  input  logic                                    ap_rst_n,
  input  logic                                    ap_start,
  output logic                                    ap_idle,
  output logic                                    ap_ready,
  output logic                                    ap_done,
  output logic                                    ap_err,
  input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]      transfer_byte,
  input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]      mem,
  output logic                                    m_axi_gmem_AWVALID,
  input  logic                                    m_axi_gmem_AWREADY,
  output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0]      m_axi_gmem_AWADDR,
  output logic [7:0]                              m_axi_gmem_AWLEN,
  output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]        m_axi_gmem_AWID,
  output logic [2:0]                              m_axi_gmem_AWSIZE,
  output logic [1:0]                              m_axi_gmem_AWBURST,
  output logic [1:0]                              m_axi_gmem_AWLOCK,
  output logic [3:0]                              m_axi_gmem_AWCACHE,
  output logic [2:0]                              m_axi_gmem_AWPROT,
  output logic [3:0]                              m_axi_gmem_AWQOS,
  output logic [3:0]                              m_axi_gmem_AWREGION,
  output logic [C_M_AXI_GMEM_AWUSER_WIDTH-1:0]    m_axi_gmem_AWUSER,
  output logic                                    m_axi_gmem_WVALID,
  input  logic                                    m_axi_gmem_WREADY,
  output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]      m_axi_gmem_WDATA,
  output logic [C_M_AXI_GMEM_DATA_WIDTH/8-1:0]    m_axi_gmem_WSTRB,
  output logic                                    m_axi_gmem_WLAST,
  output logic [C_M_AXI_GMEM_ID_WIDTH-1:0]        m_axi_gmem_WID,
  output logic [C_M_AXI_GMEM_WUSER_WIDTH-1:0]     m_axi_gmem_WUSER,
  input  logic                                    m_axi_gmem_BVALID,
  output logic                                    m_axi_gmem_BREADY,
  input  logic [1:0]                              m_axi_gmem_BRESP,
  input  logic [C_M_AXI_GMEM_ID_WIDTH-1:0]        m_axi_gmem_BID,
  input  logic [C_M_AXI_GMEM_BUSER_WIDTH-1:0]     m_axi_gmem_BUSER,
  input  logic                                    wr_en,
  output logic                                    full_n,
  input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0]      din
);

  localparam int AW    = C_M_AXI_GMEM_ADDR_WIDTH;
  localparam int BYTES = C_M_AXI_GMEM_DATA_WIDTH / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int CW    = AW - SH + 1;
  localparam int OW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0]    OUT_MAX   = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]    OUT_ONE   = OW'(1);
  localparam logic [8:0]       BURST_CAP = 9'(MAX_BURST_LEN);
  localparam logic [BYTES-1:0] STRB_ONE  = BYTES'(1);

  // Launch detection and main FSM
  state_t          st_r, st_nxt_s;
  logic            ap_start_d_r;
  logic            run_s;
  logic [CW-1:0]   tbeats_s;
  logic [CW-1:0]   total_r;
  logic [SH-1:0]   last_bytes_r;
  logic [AW-1:0]   base_r;
  logic            err_r;
  // AW path
  state_t          aw_st_r, aw_nxt_s;
  logic [CW-1:0]   aw_beats_r;
  logic [CW-1:0]   rem_s;
  logic [AW-1:0]   addr_s;
  logic [12:0]     to4k_s;
  logic [8:0]      len_s;
  logic [8:0]      len_r;
  logic            final_r;
  logic [AW-1:0]   awaddr_r;
  logic [7:0]      awlen_r;
  logic            aw_go_s;
  logic            aw_hs_s;
  logic [OW-1:0]   outst_r;
  // W path
  logic            awf_full_s, awf_empty_s;
  logic [9:0]      awf_dout_s;
  logic            aw_pop_s;
  logic            w_active_r;
  logic [8:0]      w_len_r;
  logic [8:0]      w_cnt_r;
  logic            w_final_r;
  logic            wlast_s;
  logic            w_hs_s;
  logic            w_done_s;
  logic [BYTES-1:0] strb_s;
  // B path
  logic            bf_full_s, bf_empty_s;
  logic [8:0]      bf_dout_s;
  logic            b_hs_s;
  logic [CW-1:0]   b_beats_r;
  logic            unused_ok_s;

  assign unused_ok_s = ^{mem[SH-1:0], m_axi_gmem_BID, m_axi_gmem_BUSER,
                         m_axi_gmem_BRESP[0], bf_full_s};

  assign run_s    = ap_start & ~ap_start_d_r;
  // Beat count rounded up: any residual bytes need one more (partial) beat.
  assign tbeats_s = {1'b0, transfer_byte[AW-1:SH]}
                  + {{(CW - 1){1'b0}}, |transfer_byte[SH-1:0]};

  assign ap_idle  = (st_r == ST_IDLE);
  assign ap_ready = (st_r == ST_PRE);
  assign ap_done  = (st_r == ST_DONE);
  assign ap_err   = err_r;

  // Main FSM next state
  always_comb begin
    st_nxt_s = st_r;
    case (st_r)
      ST_IDLE: begin
        if (run_s) st_nxt_s = ST_PRE;
        else       st_nxt_s = ST_IDLE;
      end
      ST_PRE: begin
        if (tbeats_s == {CW{1'b0}}) st_nxt_s = ST_DONE;
        else                        st_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (b_beats_r >= total_r) st_nxt_s = ST_DONE;
        else                      st_nxt_s = ST_RUN;
      end
      ST_DONE: st_nxt_s = ST_IDLE;
      default: st_nxt_s = ST_IDLE;
    endcase
  end

  // Main FSM state, launch edge detector, arguments latched at launch, sticky error
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_r         <= ST_IDLE;
      ap_start_d_r <= 1'b0;
      total_r      <= {CW{1'b0}};
      last_bytes_r <= {SH{1'b0}};
      base_r       <= {AW{1'b0}};
      err_r        <= 1'b0;
    end else begin
      st_r         <= st_nxt_s;
      ap_start_d_r <= ap_start;
      if (st_r == ST_PRE) begin
        total_r      <= tbeats_s;
        last_bytes_r <= transfer_byte[SH-1:0];
        base_r       <= {mem[AW-1:SH], {SH{1'b0}}};
        err_r        <= 1'b0;
      end else if (b_hs_s && (m_axi_gmem_BRESP[1] != AXI_RESP_OKAY[1])) begin
        err_r <= 1'b1;
      end
    end
  end

  // Next burst address and length. Bursts never cross a 4 KB page.
  assign rem_s   = total_r - aw_beats_r;
  assign addr_s  = base_r + {aw_beats_r[AW-SH-1:0], {SH{1'b0}}};
  assign to4k_s  = (AXI_4K - {1'b0, addr_s[11:0]}) >> SH;
  assign len_s   = burst_len(64'(rem_s), BURST_CAP, to4k_s);
  assign aw_go_s = (st_r == ST_RUN) && (aw_beats_r < total_r)
                && (outst_r < OUT_MAX) && !awf_full_s;
  assign aw_hs_s = (aw_st_r == ST_RUN) && m_axi_gmem_AWREADY;

  // AW FSM next state
  always_comb begin
    aw_nxt_s = aw_st_r;
    case (aw_st_r)
      ST_IDLE: begin
        if (aw_go_s) aw_nxt_s = ST_PRE;
        else         aw_nxt_s = ST_IDLE;
      end
      ST_PRE: aw_nxt_s = ST_RUN;
      ST_RUN: begin
        if (m_axi_gmem_AWREADY) aw_nxt_s = ST_IDLE;
        else                    aw_nxt_s = ST_RUN;
      end
      default: aw_nxt_s = ST_IDLE;
    endcase
  end

  // AW FSM state, registered burst fields, issued-beat and outstanding counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      aw_st_r    <= ST_IDLE;
      aw_beats_r <= {CW{1'b0}};
      len_r      <= 9'd0;
      final_r    <= 1'b0;
      awaddr_r   <= {AW{1'b0}};
      awlen_r    <= 8'd0;
      outst_r    <= {OW{1'b0}};
    end else begin
      aw_st_r <= aw_nxt_s;
      if (st_r == ST_PRE) begin
        aw_beats_r <= {CW{1'b0}};
      end else if (aw_hs_s) begin
        aw_beats_r <= aw_beats_r + {{(CW - 9){1'b0}}, len_r};
      end
      if (aw_st_r == ST_PRE) begin
        len_r    <= len_s;
        final_r  <= (rem_s == {{(CW - 9){1'b0}}, len_s});
        awaddr_r <= addr_s;
        awlen_r  <= len_s[7:0] - 8'd1;  // 256 beats wraps to 8'hFF
      end
      case ({aw_hs_s, b_hs_s})
        2'b10:   outst_r <= outst_r + OUT_ONE;
        2'b01:   outst_r <= outst_r - OUT_ONE;
        default: outst_r <= outst_r;
      endcase
    end
  end

  assign m_axi_gmem_AWVALID  = (aw_st_r == ST_RUN);
  assign m_axi_gmem_AWADDR   = awaddr_r;
  assign m_axi_gmem_AWLEN    = awlen_r;
  assign m_axi_gmem_AWID     = {C_M_AXI_GMEM_ID_WIDTH{1'b0}};
  assign m_axi_gmem_AWSIZE   = 3'(SH);
  assign m_axi_gmem_AWBURST  = AXI_BURST_INCR;
  assign m_axi_gmem_AWLOCK   = 2'b00;
  assign m_axi_gmem_AWCACHE  = 4'b0000;
  assign m_axi_gmem_AWPROT   = 3'b000;
  assign m_axi_gmem_AWQOS    = 4'b0000;
  assign m_axi_gmem_AWREGION = 4'b0000;
  assign m_axi_gmem_AWUSER   = {C_M_AXI_GMEM_AWUSER_WIDTH{1'b0}};

  sync_fifo #(.WIDTH(10), .DEPTH(MAX_OUTSTANDING)) u_aw_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (aw_hs_s),
    .din   ({len_r, final_r}),
    .pop   (aw_pop_s),
    .dout  (awf_dout_s),
    .full  (awf_full_s),
    .empty (awf_empty_s)
  );

  // W channel: stream beats are gated by an active burst
  assign wlast_s  = w_active_r && (w_cnt_r == (w_len_r - 9'd1));
  assign w_hs_s   = wr_en && m_axi_gmem_WREADY && w_active_r;
  assign w_done_s = w_hs_s && wlast_s;
  // Refill on the WLAST beat so consecutive bursts run without a bubble
  assign aw_pop_s = !awf_empty_s && (!w_active_r || w_done_s);

  assign m_axi_gmem_WVALID = wr_en & w_active_r;
  assign full_n            = m_axi_gmem_WREADY & w_active_r;
  assign m_axi_gmem_WDATA  = din;
  assign m_axi_gmem_WLAST  = wlast_s;
  assign m_axi_gmem_WSTRB  = strb_s;
  assign m_axi_gmem_WID    = {C_M_AXI_GMEM_ID_WIDTH{1'b0}};
  assign m_axi_gmem_WUSER  = {C_M_AXI_GMEM_WUSER_WIDTH{1'b0}};

  // Only the very last beat of a transfer may carry a partial strobe
  always_comb begin
    strb_s = {BYTES{1'b1}};
    if (w_final_r && wlast_s && (last_bytes_r != {SH{1'b0}})) begin
      strb_s = (STRB_ONE << last_bytes_r) - STRB_ONE;
    end else begin
      strb_s = {BYTES{1'b1}};
    end
  end

  // Active W burst: load from the AW->W queue, count beats, retire on WLAST
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      w_active_r <= 1'b0;
      w_len_r    <= 9'd0;
      w_cnt_r    <= 9'd0;
      w_final_r  <= 1'b0;
    end else if (aw_pop_s) begin
      w_active_r <= 1'b1;
      w_len_r    <= awf_dout_s[9:1];
      w_final_r  <= awf_dout_s[0];
      w_cnt_r    <= 9'd0;
    end else if (w_done_s) begin
      w_active_r <= 1'b0;
    end else if (w_hs_s) begin
      w_cnt_r <= w_cnt_r + 9'd1;
    end
  end

  sync_fifo #(.WIDTH(9), .DEPTH(MAX_OUTSTANDING)) u_b_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (w_done_s),
    .din   (w_len_r),
    .pop   (b_hs_s),
    .dout  (bf_dout_s),
    .full  (bf_full_s),
    .empty (bf_empty_s)
  );

  assign m_axi_gmem_BREADY = !bf_empty_s;
  assign b_hs_s            = m_axi_gmem_BVALID && !bf_empty_s;

  // Beats confirmed by write responses
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      b_beats_r <= {CW{1'b0}};
    end else if (st_r == ST_PRE) begin
      b_beats_r <= {CW{1'b0}};
    end else if (b_hs_s) begin
      b_beats_r <= b_beats_r + {{(CW - 9){1'b0}}, bf_dout_s};
    end
  end

endmodule

// File: tb/tb_wdma_mb.sv
// Directed bench for wdma_mb (64-bit data, 16-beat bursts, 2 outstanding).
// A responder models the AXI slave and the stream source. Monitors record
// AW and W handshakes. The initial block runs the directed steps and checks
// what was recorded against hand-computed values.
module tb_wdma_mb;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_idle, ap_ready, ap_done, ap_err;
  logic [31:0] transfer_byte, mem;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [0:0]  AWID;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, AWLOCK;
  logic [3:0]  AWCACHE, AWQOS, AWREGION;
  logic [2:0]  AWPROT;
  logic [0:0]  AWUSER;
  logic        WVALID, WREADY, WLAST;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic [0:0]  WID, WUSER;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic [0:0]  BID, BUSER;
  logic        wr_en, full_n;
  logic [63:0] din;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc = 0;
  int n_aw = 0, n_w = 0, done_cnt = 0, busy_seen = 0;
  int ready_cyc = 0, done_cyc = 0;
  int pend = 0, b_total = 0;
  int pend_nxt, b_total_nxt;
  int err_at = -1;
  logic b_en;
  logic [31:0] aw_addr_q [64];
  logic [7:0]  aw_len_q  [64];
  logic [7:0]  w_strb_q  [512];
  logic        w_last_q  [512];

  wdma_mb #(.MAX_OUTSTANDING(2)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done), .ap_err(ap_err),
    .transfer_byte(transfer_byte), .mem(mem),
    .m_axi_gmem_AWVALID(AWVALID), .m_axi_gmem_AWREADY(AWREADY),
    .m_axi_gmem_AWADDR(AWADDR), .m_axi_gmem_AWLEN(AWLEN),
    .m_axi_gmem_AWID(AWID), .m_axi_gmem_AWSIZE(AWSIZE),
    .m_axi_gmem_AWBURST(AWBURST), .m_axi_gmem_AWLOCK(AWLOCK),
    .m_axi_gmem_AWCACHE(AWCACHE), .m_axi_gmem_AWPROT(AWPROT),
    .m_axi_gmem_AWQOS(AWQOS), .m_axi_gmem_AWREGION(AWREGION),
    .m_axi_gmem_AWUSER(AWUSER),
    .m_axi_gmem_WVALID(WVALID), .m_axi_gmem_WREADY(WREADY),
    .m_axi_gmem_WDATA(WDATA), .m_axi_gmem_WSTRB(WSTRB),
    .m_axi_gmem_WLAST(WLAST), .m_axi_gmem_WID(WID), .m_axi_gmem_WUSER(WUSER),
    .m_axi_gmem_BVALID(BVALID), .m_axi_gmem_BREADY(BREADY),
    .m_axi_gmem_BRESP(BRESP), .m_axi_gmem_BID(BID), .m_axi_gmem_BUSER(BUSER),
    .wr_en(wr_en), .full_n(full_n), .din(din)
  );

  always #5 ap_clk = ~ap_clk;

  assign BID   = 1'b0;
  assign BUSER = 1'b0;
  assign pend_nxt    = pend + ((WVALID && WREADY && WLAST) ? 1 : 0)
                            - ((BVALID && BREADY) ? 1 : 0);
  assign b_total_nxt = b_total + ((BVALID && BREADY) ? 1 : 0);

  // Cycle counter
  always @(posedge ap_clk) cyc <= cyc + 1;

  // AXI B responder and stream source
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pend    <= 0;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
      din     <= 64'd0;
    end else begin
      pend    <= pend_nxt;
      b_total <= b_total_nxt;
      BVALID  <= b_en && (pend_nxt > 0);
      BRESP   <= (b_total_nxt == err_at) ? 2'b10 : 2'b00;
      if (wr_en && full_n) din <= din + 64'd1;
    end
  end

  // Handshake and pulse recorder
  always @(negedge ap_clk) begin
    if (AWVALID && AWREADY) begin
      if (n_aw < 64) begin
        aw_addr_q[n_aw] <= AWADDR;
        aw_len_q[n_aw]  <= AWLEN;
      end
      n_aw <= n_aw + 1;
    end
    if (WVALID && WREADY) begin
      if (n_w < 512) begin
        w_strb_q[n_w] <= WSTRB;
        w_last_q[n_w] <= WLAST;
      end
      n_w <= n_w + 1;
    end
    if (ap_ready) ready_cyc <= cyc;
    if (ap_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (AWVALID || WVALID || BREADY || full_n) busy_seen <= busy_seen + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] n);
    @(posedge ap_clk); #1;
    mem = a; transfer_byte = n; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
  endtask

  // Waits for one ap_done after count d0, bounded; then checks exactly one pulse
  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge ap_clk);
      if (done_cnt != d0) break;
    end
    repeat (3) @(posedge ap_clk);
    #1;
    chk(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  int d0, a0, w0, bs0, nlast;
  logic saw;

  initial begin
    ap_rst_n = 1'b0; ap_start = 1'b0; wr_en = 1'b0;
    transfer_byte = 32'd0; mem = 32'd0;
    AWREADY = 1'b1; WREADY = 1'b1; b_en = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_idle",    64'(ap_idle),  64'd1);
    chk("rst_ready",   64'(ap_ready), 64'd0);
    chk("rst_done",    64'(ap_done),  64'd0);
    chk("rst_err",     64'(ap_err),   64'd0);
    chk("rst_awvalid", 64'(AWVALID),  64'd0);
    chk("rst_wvalid",  64'(WVALID),   64'd0);
    chk("rst_bready",  64'(BREADY),   64'd0);
    chk("rst_full_n",  64'(full_n),   64'd0);
    ap_rst_n = 1'b1;
    wr_en = 1'b1;

    // Test 1: aligned 256 bytes -> two 16-beat bursts
    d0 = done_cnt; a0 = n_aw; w0 = n_w;
    launch(32'h1000, 32'd256);
    wait_done("t1_done", d0, 400);
    chk("t1_naw",   64'(n_aw - a0), 64'd2);
    chk("t1_addr0", 64'(aw_addr_q[a0]), 64'h1000);
    chk("t1_len0",  64'(aw_len_q[a0]),  64'd15);
    chk("t1_addr1", 64'(aw_addr_q[a0+1]), 64'h1080);
    chk("t1_len1",  64'(aw_len_q[a0+1]),  64'd15);
    chk("t1_nw",    64'(n_w - w0), 64'd32);
    nlast = 0;
    for (int i = 0; i < 32; i++) nlast += w_last_q[w0+i] ? 1 : 0;
    chk("t1_nlast", 64'(nlast), 64'd2);
    chk("t1_last16", 64'(w_last_q[w0+15]), 64'd1);
    chk("t1_last32", 64'(w_last_q[w0+31]), 64'd1);
    chk("t1_strb",   64'(w_strb_q[w0+31]), 64'hFF);
    chk("t1_err",    64'(ap_err), 64'd0);
    chk("t1_idle",   64'(ap_idle), 64'd1);

    // Test 2: 4 KB split
    d0 = done_cnt; a0 = n_aw; w0 = n_w;
    launch(32'h1FC0, 32'd256);
    wait_done("t2_done", d0, 400);
    chk("t2_naw",   64'(n_aw - a0), 64'd3);
    chk("t2_addr0", 64'(aw_addr_q[a0]),   64'h1FC0);
    chk("t2_len0",  64'(aw_len_q[a0]),    64'd7);
    chk("t2_addr1", 64'(aw_addr_q[a0+1]), 64'h2000);
    chk("t2_len1",  64'(aw_len_q[a0+1]),  64'd15);
    chk("t2_addr2", 64'(aw_addr_q[a0+2]), 64'h2080);
    chk("t2_len2",  64'(aw_len_q[a0+2]),  64'd7);
    chk("t2_nw",    64'(n_w - w0), 64'd32);
    chk("t2_last8", 64'(w_last_q[w0+7]), 64'd1);

    // Test 3: 20 bytes, unaligned base -> partial last strobe
    d0 = done_cnt; a0 = n_aw; w0 = n_w;
    launch(32'h3004, 32'd20);
    wait_done("t3_done", d0, 200);
    chk("t3_naw",   64'(n_aw - a0), 64'd1);
    chk("t3_addr",  64'(aw_addr_q[a0]), 64'h3000);
    chk("t3_len",   64'(aw_len_q[a0]),  64'd2);
    chk("t3_nw",    64'(n_w - w0), 64'd3);
    chk("t3_strb0", 64'(w_strb_q[w0]),   64'hFF);
    chk("t3_strb1", 64'(w_strb_q[w0+1]), 64'hFF);
    chk("t3_strb2", 64'(w_strb_q[w0+2]), 64'h0F);
    chk("t3_last1", 64'(w_last_q[w0+1]), 64'd0);
    chk("t3_last2", 64'(w_last_q[w0+2]), 64'd1);

    // Test 4: zero-length transfer
    d0 = done_cnt; a0 = n_aw; bs0 = busy_seen;
    launch(32'h5000, 32'd0);
    wait_done("t4_done", d0, 50);
    chk("t4_gap",  64'(done_cyc - ready_cyc), 64'd1);
    chk("t4_busy", 64'(busy_seen - bs0), 64'd0);
    chk("t4_naw",  64'(n_aw - a0), 64'd0);

    // Test 5: B withheld, 6 bursts, outstanding limit of 2
    b_en = 1'b0;
    d0 = done_cnt; a0 = n_aw; w0 = n_w;
    launch(32'h0000, 32'd768);
    repeat (150) @(posedge ap_clk);
    #1;
    chk("t5_naw_stall", 64'(n_aw - a0), 64'd2);
    chk("t5_nw_stall",  64'(n_w - w0),  64'd32);
    chk("t5_full_n",    64'(full_n), 64'd0);
    chk("t5_bready",    64'(BREADY), 64'd1);
    chk("t5_nodone",    64'(done_cnt - d0), 64'd0);
    b_en = 1'b1;
    wait_done("t5_done", d0, 800);
    chk("t5_naw", 64'(n_aw - a0), 64'd6);
    chk("t5_nw",  64'(n_w - w0),  64'd96);

    // Test 6: SLVERR on 2nd response, then cleared by next launch
    d0 = done_cnt; w0 = n_w;
    err_at = b_total + 1;
    launch(32'h4000, 32'd256);
    wait_done("t6_done", d0, 400);
    err_at = -1;
    chk("t6_err", 64'(ap_err), 64'd1);
    chk("t6_nw",  64'(n_w - w0), 64'd32);
    d0 = done_cnt;
    launch(32'h4000, 32'd0);
    wait_done("t6b_done", d0, 50);
    chk("t6_err_clr", 64'(ap_err), 64'd0);

    // Test 7: asynchronous reset mid-burst
    launch(32'h6000, 32'd256);
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge ap_clk); #1;
      if (WVALID) begin
        saw = 1'b1;
        break;
      end
    end
    chk("t7_wvalid_seen", 64'(saw), 64'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t7_awvalid", 64'(AWVALID),  64'd0);
    chk("t7_wvalid",  64'(WVALID),   64'd0);
    chk("t7_full_n",  64'(full_n),   64'd0);
    chk("t7_bready",  64'(BREADY),   64'd0);
    chk("t7_idle",    64'(ap_idle),  64'd1);
    chk("t7_ready",   64'(ap_ready), 64'd0);
    chk("t7_done",    64'(ap_done),  64'd0);
    chk("t7_err",     64'(ap_err),   64'd0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
